// File: rtl/trap_ctrl.sv
// Trap sequencer for the RV32 core: detects traps and mret in EX, then runs a
// drain / commit / redirect sequence that writes the trap CSRs and steers the PC.
module trap_ctrl #(
    parameter int XLEN         = 32,
    parameter bit SUPPORT_INTR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_instr,
    input  logic            ex_illegal_instr,
    input  logic            ex_ecall,
    input  logic            ex_ebreak,
    input  logic            ex_mret,
    input  logic            irq_external,
    input  logic            irq_software,
    input  logic            irq_timer,
    input  logic            csr_mstatus_mie,
    input  logic [2:0]      csr_mie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic            lsu_busy,
    output logic            trap_kill,
    output logic            trap_stall,
    output logic            trap_flush,
    output logic            trap_enter,
    output logic            trap_exit,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mcause,
    output logic [XLEN-1:0] trap_mtval,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_COMMIT   = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_is_exit;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_target;
    logic            r_stall;
    logic            r_flush;
    logic            r_enter;
    logic            r_exit;
    logic            r_redirect;

    logic [2:0]      w_irq_vec;
    logic            w_irq_pend;
    logic            w_event;
    logic            w_is_exit;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_mtval;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_off;
    logic [XLEN-1:0] w_target;

    assign w_irq_vec  = {irq_external, irq_software, irq_timer} & csr_mie;
    assign w_irq_pend = SUPPORT_INTR & csr_mstatus_mie & (|w_irq_vec);
    assign w_event    = ex_valid & (w_irq_pend | ex_illegal_instr | ex_ecall
                                    | ex_ebreak | ex_mret);
    assign trap_kill  = (r_state == S_IDLE) & w_event & ~rst;

    // Cause/mtval selection: interrupts first, then illegal, ebreak, ecall, mret last
    always_comb begin
        w_is_exit = 1'b0;
        w_cause   = {XLEN{1'b0}};
        w_mtval   = {XLEN{1'b0}};
        if (w_irq_pend) begin
            w_cause[XLEN-1] = 1'b1;
            if (w_irq_vec[2]) begin
                w_cause[3:0] = 4'd11;
            end else if (w_irq_vec[1]) begin
                w_cause[3:0] = 4'd3;
            end else begin
                w_cause[3:0] = 4'd7;
            end
        end else if (ex_illegal_instr) begin
            w_cause[3:0] = 4'd2;
            w_mtval      = ex_instr;
        end else if (ex_ebreak) begin
            w_cause[3:0] = 4'd3;
            w_mtval      = ex_pc;
        end else if (ex_ecall) begin
            w_cause[3:0] = 4'd11;
        end else begin
            w_is_exit = 1'b1;
        end
    end

    assign w_base    = {csr_mtvec[XLEN-1:2], 2'b00};
    assign w_vec_off = {{(XLEN-6){1'b0}}, r_cause[3:0], 2'b00};

    // Redirect target; only vectored-mode interrupts get an offset
    always_comb begin
        w_target = w_base;
        if (r_is_exit) begin
            w_target = csr_mepc;
        end else if ((csr_mtvec[1:0] == 2'b01) && r_cause[XLEN-1]) begin
            w_target = w_base + w_vec_off;
        end else begin
            w_target = w_base;
        end
    end

    // Sequencer state, latched trap data and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_exit  <= 1'b0;
            r_mepc     <= {XLEN{1'b0}};
            r_cause    <= {XLEN{1'b0}};
            r_mtval    <= {XLEN{1'b0}};
            r_target   <= {XLEN{1'b0}};
            r_stall    <= 1'b0;
            r_flush    <= 1'b0;
            r_enter    <= 1'b0;
            r_exit     <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_enter    <= 1'b0;
            r_exit     <= 1'b0;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_is_exit <= w_is_exit;
                        r_mepc    <= ex_pc;
                        r_cause   <= w_cause;
                        r_mtval   <= w_mtval;
                        r_stall   <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_stall   <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!lsu_busy) begin
                        r_enter <= ~r_is_exit;
                        r_exit  <= r_is_exit;
                        r_state <= S_COMMIT;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_COMMIT: begin
                    r_target   <= w_target;
                    r_stall    <= 1'b0;
                    r_redirect <= 1'b1;
                    r_flush    <= 1'b1;
                    r_state    <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_stall <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trap_stall  = r_stall;
    assign trap_flush  = r_flush;
    assign trap_enter  = r_enter;
    assign trap_exit   = r_exit;
    assign trap_mepc   = r_mepc;
    assign trap_mcause = r_cause;
    assign trap_mtval  = r_mtval;
    assign pc_redirect = r_redirect;
    assign pc_target   = r_target;

endmodule
